// File: rtl/dt_sti_loader_pkg.sv
// Shared constants and FSM state type for the distance-transform datapath.
// Used by dt_sti_loader, dt_pix_shifter and the DT core.
package dt_pkg;

   localparam int IMG_W     = 128;
   localparam int WORD_W    = 16;
   localparam int ROM_AW    = 10;
   localparam int RES_AW    = 14;
   localparam int ROM_WORDS = IMG_W * IMG_W / WORD_W;

   localparam logic [7:0] FG_VAL = 8'd1;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      STREAM,
      FIN
   } state_t;

endpackage

// File: rtl/dt_sti_loader_pix_shifter.sv
// dt_pix_shifter: holds the current sti_ROM word and steps through its 16 pixels MSB first.
// next_bit is the pixel that follows the one currently being written.
module dt_pix_shifter
   import dt_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] din,
   output logic              next_bit,
   output logic [3:0]        pix_idx,
   output logic              last_pix
);

   logic [WORD_W-1:0] bits;

   // Rotating rather than zero-filling keeps every bit of the word live.
   always_ff @(posedge clk) begin
      if (reset) begin
         bits    <= '0;
         pix_idx <= '0;
      end else if (load) begin
         bits    <= din;
         pix_idx <= '0;
      end else if (shift) begin
         bits    <= {bits[WORD_W-2:0], bits[WORD_W-1]};
         pix_idx <= pix_idx + 4'd1;
      end
   end

   assign next_bit = bits[WORD_W-2];
   assign last_pix = (pix_idx == 4'd15);

endmodule

// File: rtl/dt_sti_loader.sv
// dt_sti_loader: unpacks sti_ROM words into one seed byte per pixel of res_RAM, one write per clock.
// Optional macro DT_BORDER_CLEAR_EN forces the outer ring of the image to 0.
module dt_sti_loader
   import dt_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              sti_rd,
   output logic [ROM_AW-1:0] sti_addr,
   input  logic [WORD_W-1:0] sti_di,
   output logic              res_wr,
   output logic [RES_AW-1:0] res_addr,
   output logic [7:0]        res_do
);

   state_t            state;
   logic [ROM_AW-1:0] word;
   logic              last_word;
   logic              load;
   logic              shift;
   logic              next_bit;
   logic [3:0]        pix_idx;
   logic              last_pix;
   logic [RES_AW-1:0] next_addr;
   logic              pix_src;
   logic              border;
   logic [7:0]        pix_val;

   dt_pix_shifter u_shifter (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .shift    (shift),
      .din      (sti_di),
      .next_bit (next_bit),
      .pix_idx  (pix_idx),
      .last_pix (last_pix)
   );

   assign last_word = (word == ROM_AW'(ROM_WORDS - 1));

   // A fresh ROM word arrives after FETCH and at every word boundary except the final one.
   always_comb begin
      load      = (state == FETCH) || ((state == STREAM) && last_pix && !last_word);
      shift     = (state == STREAM) && !last_pix;
      next_addr = (state == STREAM) ? res_addr + 1'b1 : '0;
      pix_src   = ((state == FETCH) || last_pix) ? sti_di[WORD_W-1] : next_bit;
   end

`ifdef DT_BORDER_CLEAR_EN
   logic [6:0] row;
   logic [6:0] col;
   assign row    = next_addr[13:7];
   assign col    = next_addr[6:0];
   assign border = (row == 7'd0) || (row == 7'(IMG_W - 1)) ||
                   (col == 7'd0) || (col == 7'(IMG_W - 1));
`else
   assign border = 1'b0;
`endif

   assign pix_val = (pix_src && !border) ? FG_VAL : 8'd0;

   // Sequencer; the prefetch read is issued one cycle ahead so the new word lands exactly at the boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         word     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sti_rd   <= 1'b0;
         sti_addr <= '0;
         res_wr   <= 1'b0;
         res_addr <= '0;
         res_do   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state    <= FETCH;
                  busy     <= 1'b1;
                  sti_rd   <= 1'b1;
                  sti_addr <= '0;
               end
            end
            FETCH: begin
               state    <= STREAM;
               word     <= '0;
               sti_rd   <= 1'b0;
               res_wr   <= 1'b1;
               res_addr <= next_addr;
               res_do   <= pix_val;
            end
            STREAM: begin
               if (last_pix && last_word) begin
                  state  <= FIN;
                  res_wr <= 1'b0;
                  done   <= 1'b1;
               end else begin
                  res_addr <= next_addr;
                  res_do   <= pix_val;
                  if (last_pix) begin
                     word   <= word + 1'b1;
                     sti_rd <= 1'b0;
                  end else if ((pix_idx == 4'd14) && !last_word) begin
                     sti_rd   <= 1'b1;
                     sti_addr <= word + 1'b1;
                  end
               end
            end
            FIN: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
